pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline control unit that produces the stall and flush signals consumed by the Fetch-Decode and Decode-Execute pipeline registers. It tracks destination registers in flight in EX and MEM, detects read-after-write hazards on the instruction in Decode, serialises FFT-engine instructions against a busy engine, and squashes wrong-path instructions after a taken branch. It sits beside the Decode stage and is the sole driver of every `*_stall` / `*_flush` pipe input.

## Interface
- `REGW`, 3, register-index width (8 architectural registers)
- `BRANCH_PENALTY`, 2, cycles of front-end flush after a taken branch (legal 1..3)
- `CNTW`, 16, width of the stall-cycle counter
- `clk` in 1: single clock, all state on posedge
- `rst` in 1: reset, synchronous, active-high
- `dec_valid` in 1: Decode holds a real instruction
- `dec_rs_a`, `dec_rs_b` in REGW: source register indices
- `dec_use_a`, `dec_use_b` in 1: source is actually read
- `dec_wr_en` in 1: instruction writes `dec_wr_reg`
- `dec_wr_reg` in REGW: destination index
- `dec_mem_rd` in 1: instruction is a load (result available after MEM)
- `dec_fft` in 1: instruction issues to the FFT engine
- `ex_branch_taken` in 1: branch in EX resolved taken this cycle
- `fft_busy` in 1: FFT engine cannot accept a command
- `fetch_stall`, `fd_stall`, `de_stall` out 1: hold PC / FD / DE registers
- `fd_flush`, `de_flush` out 1: clear FD / DE registers next edge
- `stall_cycles` out CNTW: saturating count of cycles with `fd_stall` high

## Operation
- FSM states: IDLE, FFT_WAIT, REDIRECT. Reset → IDLE, scoreboard cleared, redirect counter 0, `stall_cycles` 0.
- Scoreboard: two entries, EX and MEM, each {valid, wr_reg, mem_rd}. Every cycle MEM←EX; EX←decode info if decode issues (`dec_valid` & no stall & no flush & `dec_wr_en`), else invalid. Back end never stalls.
- RAW hazard: used source matches `wr_reg` of a valid EX or MEM entry. Register 0 is not special. WB is write-before-read, so it is never a hazard.
- Priority (highest first): taken branch, FFT wait, RAW stall.
- Taken branch (any state): `fd_flush`=`de_flush`=1, no stalls; go to REDIRECT with counter = `BRANCH_PENALTY`-1. In REDIRECT, `fd_flush`=`de_flush`=1 while the counter is nonzero; the counter decrements; return to IDLE when it reaches 0. A new taken branch while in REDIRECT reloads the counter.
- FFT: in IDLE with `dec_valid`&`dec_fft`&`fft_busy`, go to FFT_WAIT. In FFT_WAIT, stall. On the first cycle `fft_busy`=0, stall is released the same cycle and the state returns to IDLE.
- Stall encoding: `fetch_stall`=`fd_stall`=1, `de_flush`=1 (bubble into EX), `de_stall`=0. `de_stall` is reserved and is tied 0 in this block.
- `stall_cycles` increments on every cycle with `fd_stall`=1 and saturates at all-ones.

## Timing
- All stall/flush outputs are combinational from current state, scoreboard and decode/EX inputs, and act on the next clock edge.
- A RAW stall without forwarding lasts 2 cycles for an EX match and 1 cycle for a MEM-only match.
- Branch cost: `BRANCH_PENALTY` flushed cycles, including the resolve cycle.
- While `rst`=1: `fd_flush`=`de_flush`=1 and all stalls 0. Reset mid-stall or mid-redirect abandons the operation; the next cycle is IDLE.
- A branch together with an FFT or RAW condition produces a flush only, with no stall count. The Decode instruction is killed and never enters the scoreboard.

## Configuration
- `PIPE_FORWARDING_EN` defined: only a load-use hazard stalls, i.e. a used source matching a valid EX entry with `mem_rd`=1, for 1 cycle. The MEM entry never causes a stall.
- `PIPE_FORWARDING_EN` undefined: full RAW stall rules apply as above.

## Structure
- `pipe_ctrl_pkg`: state enum (IDLE/FFT_WAIT/REDIRECT), scoreboard entry struct, default `REGW`/`CNTW`.
- Sub-module `hazard_scoreboard`: holds the EX/MEM entries and outputs `raw_hazard`. The forwarding macro is applied inside it.

## Test plan
- Without forwarding, `R3`←add, next instruction reads `R3`: `fd_stall`=1 for 2 cycles, `de_flush`=1 both cycles, `stall_cycles`=2.
- With `PIPE_FORWARDING_EN`, load to `R5` then a reader of `R5`: exactly 1 stall cycle. ALU producer to `R5` then a reader: 0 stall cycles.
- `ex_branch_taken` pulse with `BRANCH_PENALTY`=2: `fd_flush`/`de_flush` high for 2 cycles. A second taken pulse on the 2nd cycle extends the flush to 3 cycles total.
- `dec_fft` with `fft_busy` high for 5 cycles: stall for 5 cycles, release in the cycle `fft_busy` falls. A branch taken on the 3rd of those cycles gives a flush, REDIRECT, and no further stall.
- Reset asserted during FFT_WAIT and during REDIRECT: both flushes high, stalls 0, IDLE on release, and `stall_cycles`=0.
- Saturation with `CNTW`=4: 20 consecutive stall cycles leave `stall_cycles`=15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, scoreboard
// entry layout, default widths and the source-match helper.
package pipe_ctrl_pkg;

    localparam int REGW_DEF = 3;
    localparam int CNTW_DEF = 16;
    // Scoreboard stores indices at a fixed width; narrower REGW zero-extends.
    localparam int SB_REGW  = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FFT_WAIT = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [SB_REGW-1:0] wr_reg;
        logic               mem_rd;
    } sb_entry_t;

    // A used source that names the destination of a live in-flight entry.
    function automatic logic src_hit(input sb_entry_t e,
                                     input logic [SB_REGW-1:0] rs,
                                     input logic use_src);
        return use_src & e.valid & (e.wr_reg == rs);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/EX side-band bus between the pipeline and the hazard controller.
// master = pipeline (drives decode info), slave = controller (drives stall/flush).
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int REGW = REGW_DEF,
    parameter int CNTW = CNTW_DEF
);
    logic            dec_valid;
    logic [REGW-1:0] dec_rs_a;
    logic [REGW-1:0] dec_rs_b;
    logic            dec_use_a;
    logic            dec_use_b;
    logic            dec_wr_en;
    logic [REGW-1:0] dec_wr_reg;
    logic            dec_mem_rd;
    logic            dec_fft;
    logic            ex_branch_taken;
    logic            fft_busy;
    logic            fetch_stall;
    logic            fd_stall;
    logic            de_stall;
    logic            fd_flush;
    logic            de_flush;
    logic [CNTW-1:0] stall_cycles;

    modport master (
        output dec_valid, dec_rs_a, dec_rs_b, dec_use_a, dec_use_b,
               dec_wr_en, dec_wr_reg, dec_mem_rd, dec_fft,
               ex_branch_taken, fft_busy,
        input  fetch_stall, fd_stall, de_stall, fd_flush, de_flush, stall_cycles
    );

    modport slave (
        input  dec_valid, dec_rs_a, dec_rs_b, dec_use_a, dec_use_b,
               dec_wr_en, dec_wr_reg, dec_mem_rd, dec_fft,
               ex_branch_taken, fft_busy,
        output fetch_stall, fd_stall, de_stall, fd_flush, de_flush, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// EX/MEM destination scoreboard and RAW detection for the Decode instruction.
// Macro PIPE_FORWARDING_EN: only a load in EX feeding a used source stalls.
module hazard_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int REGW = REGW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue,
    input  logic [REGW-1:0] wr_reg,
    input  logic            mem_rd,
    input  logic [REGW-1:0] rs_a,
    input  logic [REGW-1:0] rs_b,
    input  logic            use_a,
    input  logic            use_b,
    output logic            raw_hazard
);
    sb_entry_t ex_q, mem_q;
    logic      ex_hit, mem_hit;

    // Back end never stalls: entries advance every cycle, EX refills from Decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            mem_q <= ex_q;
            if (issue)
                ex_q <= '{valid: 1'b1, wr_reg: SB_REGW'(wr_reg), mem_rd: mem_rd};
            else
                ex_q <= '0;
        end
    end

    assign ex_hit  = src_hit(ex_q,  SB_REGW'(rs_a), use_a) | src_hit(ex_q,  SB_REGW'(rs_b), use_b);
    assign mem_hit = src_hit(mem_q, SB_REGW'(rs_a), use_a) | src_hit(mem_q, SB_REGW'(rs_b), use_b);

`ifdef PIPE_FORWARDING_EN
    // ALU results bypass from EX/MEM; only load data is late by one cycle.
    assign raw_hazard = ex_hit & ex_q.mem_rd;
`else
    // No bypass: any producer still in EX or MEM blocks the read (WB writes first).
    assign raw_hazard = ex_hit | mem_hit;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: sole driver of fetch/FD/DE stall and flush.
// Branch redirect > FFT serialisation > RAW stall. Forwarding behaviour is
// selected inside hazard_scoreboard by macro PIPE_FORWARDING_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REGW           = REGW_DEF,
    parameter int BRANCH_PENALTY = 2,
    parameter int CNTW           = CNTW_DEF
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave hz
);
    // Resolve cycle is the first flushed cycle, so REDIRECT covers the rest.
    localparam logic [1:0] RELOAD = 2'(BRANCH_PENALTY - 1);

    state_t          state, state_nxt;
    logic [1:0]      rcnt, rcnt_nxt;
    logic [CNTW-1:0] stall_cnt;
    logic            raw_hazard, redirect_flush, idle_like, fft_req;
    logic            fft_stall, kill, stall, flush, issue;

    assign redirect_flush = (state == REDIRECT) && (rcnt != 2'd0);
    assign idle_like      = (state == IDLE) || ((state == REDIRECT) && (rcnt == 2'd0));
    assign fft_req        = hz.dec_valid & hz.dec_fft & hz.fft_busy;
    assign fft_stall      = ((state == FFT_WAIT) && hz.fft_busy) || (idle_like && fft_req);
    assign kill           = hz.ex_branch_taken | redirect_flush;
    assign stall          = ~rst & ~kill & (fft_stall | (hz.dec_valid & raw_hazard));
    assign flush          = rst | kill;
    // Killed or stalled Decode instructions never reach the scoreboard.
    assign issue          = hz.dec_valid & hz.dec_wr_en & ~stall & ~flush;

    hazard_scoreboard #(.REGW(REGW)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .issue      (issue),
        .wr_reg     (hz.dec_wr_reg),
        .mem_rd     (hz.dec_mem_rd),
        .rs_a       (hz.dec_rs_a),
        .rs_b       (hz.dec_rs_b),
        .use_a      (hz.dec_use_a),
        .use_b      (hz.dec_use_b),
        .raw_hazard (raw_hazard)
    );

    // State and redirect-counter register; reset abandons any stall or redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rcnt  <= 2'd0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
        end
    end

    // Next state: a taken branch wins from any state and (re)loads the counter.
    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        if (hz.ex_branch_taken) begin
            state_nxt = REDIRECT;
            rcnt_nxt  = RELOAD;
        end else begin
            case (state)
                IDLE:     if (fft_req) state_nxt = FFT_WAIT;
                FFT_WAIT: if (!hz.fft_busy) state_nxt = IDLE;
                REDIRECT: begin
                    if (rcnt == 2'd0) begin
                        state_nxt = fft_req ? FFT_WAIT : IDLE;
                    end else begin
                        rcnt_nxt = rcnt - 2'd1;
                        if (rcnt == 2'd1) state_nxt = IDLE;
                    end
                end
                default:  state_nxt = IDLE;
            endcase
        end
    end

    // Outputs: a stall injects a bubble into EX; de_stall is never used here.
    always_comb begin
        hz.fetch_stall = stall;
        hz.fd_stall    = stall;
        hz.de_stall    = 1'b0;
        hz.fd_flush    = flush;
        hz.de_flush    = flush | stall;
    end

    // Saturating count of cycles spent with the front end held.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != {CNTW{1'b1}}))
            stall_cnt <= stall_cnt + CNTW'(1);
    end

    assign hz.stall_cycles = stall_cnt;

endmodule
